// File: rtl/ucontrol.sv
// ----------------------------------------------------------------------------
// ucontrol -- microcontroller control unit
//
// Three-state sequencer (BOOT, RUN, HALT). In RUN, the 6-bit opcode is
// decoded combinationally into datapath controls in the same cycle. The unit
// also keeps a free-running count of executed instructions.
//
// Ports:
//   clk     in   1  system clock, all state changes on its rising edge
//   reset   in   1  synchronous active-high reset
//   Opcode  in   6  instruction bits [15:10]
//   z       in   1  registered zero flag from the datapath
//   cont    in   1  resume request while halted
//   s_inc   out  1  PC mux select (0 = PC+1, 1 = jump target)
//   s_inm   out  1  immediate path select
//   we3     out  1  register file write enable
//   wez     out  1  zero-flag write enable
//   Op      out  3  ALU operation
//   pc_en   out  1  PC update enable
//   halted  out  1  high while in HALT
//   icount  out 16  executed-instruction count (wraps)
// ----------------------------------------------------------------------------
module ucontrol (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        z,
  input  logic        cont,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  Op,
  output logic        pc_en,
  output logic        halted,
  output logic [15:0] icount
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] icount_q, icount_d;

  assign icount = icount_q;

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    s_inc    = 1'b0;
    s_inm    = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    Op       = 3'b000;
    pc_en    = 1'b0;
    halted   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        pc_en    = 1'b1;
        // The HALT opcode cycle is itself an executed instruction.
        icount_d = icount_q + 16'd1;
        if (Opcode[5]) begin
          // ALU operation: function field is Opcode[4:2]
          Op  = Opcode[4:2];
          we3 = 1'b1;
          wez = 1'b1;
        end else if (!Opcode[4]) begin
          // load immediate
          s_inm = 1'b1;
          we3   = 1'b1;
        end else begin
          // control-flow group 01xxxx; z is the registered flag as presented
          case (Opcode[3:0])
            4'b0000: s_inc = 1'b1;
            4'b0001: s_inc = z;
            4'b0010: s_inc = ~z;
            4'b0011: begin
              pc_en   = 1'b0;
              state_d = ST_HALT;
            end
            default: ; // NOP
          endcase
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        // Stepping the PC on resume moves it past the HALT instruction.
        if (cont) begin
          pc_en   = 1'b1;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      icount_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

endmodule

// File: tb/tb_ucontrol.sv
// ----------------------------------------------------------------------------
// tb_ucontrol -- self-checking bench for ucontrol.
// A behavioural model (mode + instruction count) is advanced at every rising
// edge from the inputs applied before that edge; expected controls are derived
// from the opcode rules directly.
// ----------------------------------------------------------------------------
module tb_ucontrol;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = 6'b010100;
  logic        z = 1'b0;
  logic        cont = 1'b0;
  logic        s_inc, s_inm, we3, wez, pc_en, halted;
  logic [2:0]  Op;
  logic [15:0] icount;

  int total = 0;
  int bad   = 0;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b010011;
  localparam logic [5:0] OP_NOP  = 6'b010100;

  int          m_mode = M_BOOT;
  logic [15:0] m_cnt  = 16'h0000;

  logic [8:0] ctrl;
  assign ctrl = {s_inc, s_inm, we3, wez, Op, pc_en, halted};

  ucontrol dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .cont(cont),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  // Expected {s_inc,s_inm,we3,wez,Op[2:0],pc_en,halted}
  function automatic logic [8:0] exp_ctrl(int mode, logic [5:0] opc, logic zz, logic cc);
    logic e_inc, e_inm, e_we3, e_wez, e_pc, e_halt;
    logic [2:0] e_op;
    int grp;
    e_inc = 0; e_inm = 0; e_we3 = 0; e_wez = 0; e_pc = 0; e_halt = 0; e_op = 3'd0;
    if (mode == M_HALT) begin
      e_halt = 1;
      e_pc   = cc;
    end else if (mode == M_RUN) begin
      e_pc = 1;
      grp  = int'(opc) / 16;
      if (grp >= 2) begin
        e_op  = 3'((int'(opc) / 4) % 8);
        e_we3 = 1;
        e_wez = 1;
      end else if (grp == 0) begin
        e_inm = 1;
        e_we3 = 1;
      end else if (opc == OP_J)    e_inc = 1;
      else if (opc == OP_JZ)       e_inc = zz;
      else if (opc == OP_JNZ)      e_inc = !zz;
      else if (opc == OP_HALT)     e_pc  = 0;
    end
    return {e_inc, e_inm, e_we3, e_wez, e_op, e_pc, e_halt};
  endfunction

  task automatic drive(input logic [5:0] opc, input logic zz, input logic cc, input logic rst);
    Opcode = opc; z = zz; cont = cc; reset = rst;
    #2;
  endtask

  // One clock edge; the model consumes the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = M_BOOT;
      m_cnt  = 16'h0000;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_cnt = m_cnt + 16'd1;
      if (Opcode == OP_HALT) m_mode = M_HALT;
    end else if (cont) begin
      m_mode = M_RUN;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(OP_NOP, 0, 0, 1); tick(); tick();
    drive(OP_NOP, 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(OP_HALT, 1, 1, 1); tick();
    for (int i = 0; i < 2; i++) begin
      drive(OP_HALT, 1, 1, 1);
      total++;
      if (ctrl !== 9'd0 || icount !== 16'h0000) begin
        bad++;
        $display("FAIL reset_hold: ctrl=%b icount=%h required ctrl=000000000 icount=0000", ctrl, icount);
      end
      tick();
    end
    drive(OP_J, 1, 1, 0);
    total++;
    if (pc_en !== 1'b0 || we3 !== 1'b0 || halted !== 1'b0 || icount !== 16'h0000) begin
      bad++;
      $display("FAIL boot_cycle: pc_en=%b we3=%b halted=%b icount=%h required 0 0 0 0000", pc_en, we3, halted, icount);
    end
    tick();
    drive(OP_NOP, 0, 0, 0);
    total++;
    if (pc_en !== 1'b1 || icount !== 16'h0000) begin
      bad++;
      $display("FAIL first_run: pc_en=%b icount=%h required 1 0000", pc_en, icount);
    end
    tick();
    drive(OP_NOP, 0, 0, 0);
    total++;
    if (icount !== 16'h0001) begin
      bad++;
      $display("FAIL run_incr: icount=%h required 0001", icount);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    do_reset();
    drive(6'b101100, 0, 0, 0);
    total++;
    if (ctrl !== 9'b0_0_1_1_011_1_0) begin
      bad++;
      $display("FAIL alu_101100: ctrl=%b required 001101110", ctrl);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      logic [5:0] opc;
      opc = 6'($urandom_range(32, 63));
      drive(opc, 1'($urandom), 1'($urandom), 0);
      total++;
      if (ctrl !== exp_ctrl(m_mode, opc, z, cont) || icount !== m_cnt) begin
        bad++;
        $display("FAIL alu_rand op=%b: ctrl=%b icount=%h required ctrl=%b icount=%h",
                 opc, ctrl, icount, exp_ctrl(m_mode, opc, z, cont), m_cnt);
      end
      tick();
    end
    $display("test_alu done");
  endtask

  task automatic test_jumps();
    logic [5:0] ops  [4] = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ};
    logic       zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       incs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], zs[i], 0, 0);
      total++;
      if (s_inc !== incs[i] || we3 !== 1'b0 || wez !== 1'b0 || s_inm !== 1'b0 || Op !== 3'd0 || pc_en !== 1'b1) begin
        bad++;
        $display("FAIL jump op=%b z=%b: s_inc=%b we3=%b wez=%b s_inm=%b Op=%b pc_en=%b required s_inc=%b others 0, pc_en=1",
                 ops[i], zs[i], s_inc, we3, wez, s_inm, Op, pc_en, incs[i]);
      end
      tick();
    end
    drive(OP_J, 0, 0, 0);
    total++;
    if (s_inc !== 1'b1) begin
      bad++;
      $display("FAIL jump_j: s_inc=%b required 1", s_inc);
    end
    tick();
    drive(6'b000101, 0, 0, 0);
    total++;
    if (ctrl !== 9'b0_1_1_0_000_1_0) begin
      bad++;
      $display("FAIL load_imm: ctrl=%b required 011000010", ctrl);
    end
    tick();
    $display("test_jumps done");
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    do_reset();
    drive(OP_NOP, 0, 1, 0); tick();
    drive(OP_HALT, 0, 0, 0);
    total++;
    if (pc_en !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_op: pc_en=%b halted=%b required 0 0", pc_en, halted);
    end
    frozen = m_cnt + 16'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(6'($urandom), 1'($urandom), 0, 0);
      total++;
      if (halted !== 1'b1 || pc_en !== 1'b0 || we3 !== 1'b0 || wez !== 1'b0 || s_inc !== 1'b0 || icount !== frozen) begin
        bad++;
        $display("FAIL halt_hold: halted=%b pc_en=%b we3=%b wez=%b s_inc=%b icount=%h required 1 0 0 0 0 %h",
                 halted, pc_en, we3, wez, s_inc, icount, frozen);
      end
      tick();
    end
    drive(6'b111111, 1, 1, 0);
    total++;
    if (pc_en !== 1'b1 || we3 !== 1'b0 || wez !== 1'b0 || s_inc !== 1'b0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_resume: pc_en=%b we3=%b wez=%b s_inc=%b halted=%b required 1 0 0 0 1",
               pc_en, we3, wez, s_inc, halted);
    end
    tick();
    drive(OP_NOP, 0, 0, 0);
    total++;
    if (halted !== 1'b0 || pc_en !== 1'b1 || icount !== frozen) begin
      bad++;
      $display("FAIL after_resume: halted=%b pc_en=%b icount=%h required 0 1 %h", halted, pc_en, icount, frozen);
    end
    tick();
    $display("test_halt done");
  endtask

  task automatic test_reset_halted();
    do_reset();
    drive(OP_HALT, 0, 0, 0); tick();
    drive(OP_NOP, 0, 1, 1); tick();
    drive(OP_NOP, 0, 0, 0);
    total++;
    if (halted !== 1'b0 || icount !== 16'h0000 || ctrl !== 9'd0) begin
      bad++;
      $display("FAIL reset_halted: halted=%b icount=%h ctrl=%b required 0 0000 000000000", halted, icount, ctrl);
    end
    tick();
    $display("test_reset_halted done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [5:0] opc;
      logic       rst;
      opc = ($urandom_range(0, 7) == 0) ? OP_HALT : 6'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      drive(opc, 1'($urandom), 1'($urandom_range(0, 3) == 0), rst);
      total++;
      if (ctrl !== exp_ctrl(m_mode, opc, z, cont) || icount !== m_cnt) begin
        bad++;
        $display("FAIL random i=%0d op=%b z=%b cont=%b: ctrl=%b icount=%h required ctrl=%b icount=%h",
                 i, opc, z, cont, ctrl, icount, exp_ctrl(m_mode, opc, z, cont), m_cnt);
      end
      tick();
    end
    $display("test_random done");
  endtask

  task automatic test_wrap();
    do_reset();
    drive(OP_NOP, 0, 0, 0);
    for (int i = 0; i < 65535; i++) tick();
    total++;
    if (icount !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: icount=%h required ffff", icount);
    end
    tick();
    total++;
    if (icount !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: icount=%h required 0000", icount);
    end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jumps();
    test_halt();
    test_reset_halted();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
